// File: rtl/game_input_conditioner.sv
// Synchronises, debounces and edge-detects the board's KEY/SW inputs for the game FSM.
// Optional macro SW_ONEHOT_EN: register SW as one-hot-only and flag multiple raised switches.
module game_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] KEY,
  input  logic [9:0] SW_raw,
  output logic       select1,
  output logic       select2,
  output logic       userquit,
  output logic       start_pulse,
  output logic [3:0] key_held,
  output logic [9:0] SW,
  output logic       sw_multi
);

  localparam int NCH = 14;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]     keySync1_q, keySync2_q;
  logic [9:0]     swSync1_q, swSync2_q;
  logic [NCH-1:0] syncVal;
  logic [NCH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [3:0]     rise_q, rise_d;

  // Keys reset to "released" so a button held through reset is seen as a fresh press.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      keySync1_q <= 4'hF;
      keySync2_q <= 4'hF;
      swSync1_q  <= '0;
      swSync2_q  <= '0;
    end else begin
      keySync1_q <= KEY;
      keySync2_q <= keySync1_q;
      swSync1_q  <= SW_raw;
      swSync2_q  <= swSync1_q;
    end
  end

  assign syncVal = {swSync2_q, ~keySync2_q};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (syncVal[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = syncVal[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = stable_d[3:0] & ~stable_q[3:0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stable_q <= '0;
      rise_q   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Quit wins over the two select buttons in the same cycle; start is independent.
  assign key_held    = stable_q[3:0];
  assign userquit    = rise_q[2];
  assign select1     = rise_q[0] & ~rise_q[2];
  assign select2     = rise_q[1] & ~rise_q[2];
  assign start_pulse = rise_q[3];

`ifdef SW_ONEHOT_EN
  logic [9:0] swStable;
  logic       swAny, swOne;
  logic [9:0] sw_q;
  logic       multi_q;

  assign swStable = stable_q[13:4];
  assign swAny    = |swStable;
  assign swOne    = swAny && ((swStable & (swStable - 10'd1)) == 10'd0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw_q    <= '0;
      multi_q <= 1'b0;
    end else begin
      sw_q    <= swOne ? swStable : 10'd0;
      multi_q <= swAny && !swOne;
    end
  end

  assign SW       = sw_q;
  assign sw_multi = multi_q;
`else
  assign SW       = stable_q[13:4];
  assign sw_multi = 1'b0;
`endif

endmodule

// File: tb/tb_game_input_conditioner.sv
// Self-checking bench for game_input_conditioner: directed scenarios plus random bouncing inputs
// compared each cycle against a window-based reference model.
module tb_game_input_conditioner;

  localparam int DC = 4;
`ifdef SW_ONEHOT_EN
  localparam int SW_LAT = 7;
`else
  localparam int SW_LAT = 6;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [3:0] KEY;
  logic [9:0] SW_raw;
  logic       select1, select2, userquit, start_pulse;
  logic [3:0] key_held;
  logic [9:0] SW;
  logic       sw_multi;

  always #5 CLOCK_50 = ~CLOCK_50;

  game_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .KEY        (KEY),
    .SW_raw     (SW_raw),
    .select1    (select1),
    .select2    (select2),
    .userquit   (userquit),
    .start_pulse(start_pulse),
    .key_held   (key_held),
    .SW         (SW),
    .sw_multi   (sw_multi)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a channel's stable value flips once the last DC synchronised
  // samples (raw delayed by two cycles) all disagree with it.
  logic [13:0] rawQ [$];
  logic [13:0] win  [$];
  logic [13:0] mStable;
  logic [3:0]  mRose;
  logic [9:0]  mSw;
  logic        mMulti;

  int nSel1, nSel2, nQuit, nStart;
  int lastSel1, lastSel2, lastStart;
  logic [3:0] quitHeld;
  logic       quitSel1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic modelEdge(input logic [3:0] k, input logic [9:0] s, input logic r);
    logic [13:0] prev, samp, nxt;
    logic        allDiff;
    int          ones;
    if (r) begin
      rawQ = {14'h0, 14'h0};
      win.delete();
      mStable = '0;
      mRose   = '0;
      mSw     = '0;
      mMulti  = 1'b0;
    end else begin
      prev = mStable;
      samp = rawQ.pop_front();
      rawQ.push_back({s, ~k});
      win.push_back(samp);
      if (win.size() > DC) void'(win.pop_front());
      nxt = mStable;
      if (win.size() == DC) begin
        for (int i = 0; i < 14; i++) begin
          allDiff = 1'b1;
          foreach (win[j]) if (win[j][i] == mStable[i]) allDiff = 1'b0;
          if (allDiff) nxt[i] = ~mStable[i];
        end
      end
      mRose   = nxt[3:0] & ~prev[3:0];
      mStable = nxt;
`ifdef SW_ONEHOT_EN
      ones   = $countones(prev[13:4]);
      mSw    = (ones == 1) ? prev[13:4] : 10'd0;
      mMulti = (ones >= 2);
`else
      ones   = 0;
      mSw    = mStable[13:4];
      mMulti = 1'b0;
`endif
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k, input logic [9:0] s, input logic r);
    KEY    = k;
    SW_raw = s;
    reset  = r;
    @(posedge CLOCK_50);
    modelEdge(k, s, r);
    #1;
    checkOutput();
    if (select1)     begin nSel1++;  lastSel1  = cyc + 1; end
    if (select2)     begin nSel2++;  lastSel2  = cyc + 1; end
    if (start_pulse) begin nStart++; lastStart = cyc + 1; end
    if (userquit)    begin nQuit++;  quitHeld = key_held; quitSel1 = select1; end
    cyc++;
  endtask

  task automatic checkOutput();
    chk("key_held",    32'(key_held),    32'(mStable[3:0]));
    chk("select1",     32'(select1),     32'(mRose[0] & ~mRose[2]));
    chk("select2",     32'(select2),     32'(mRose[1] & ~mRose[2]));
    chk("userquit",    32'(userquit),    32'(mRose[2]));
    chk("start_pulse", 32'(start_pulse), 32'(mRose[3]));
    chk("SW",          32'(SW),          32'(mSw));
    chk("sw_multi",    32'(sw_multi),    32'(mMulti));
  endtask

  task automatic clearCounts();
    nSel1 = 0; nSel2 = 0; nQuit = 0; nStart = 0;
    lastSel1 = -1; lastSel2 = -1; lastStart = -1;
    quitHeld = 4'h0; quitSel1 = 1'b1;
  endtask

  initial begin
    int dropC, finalC, swC, rstC;
    logic [3:0] k;
    logic [9:0] s;
    logic r;
    rawQ = {14'h0, 14'h0};
    mStable = '0; mRose = '0; mSw = '0; mMulti = 1'b0;
    clearCounts();

    // Reset with everything released
    repeat (3) applyStimulus(4'hF, 10'h0, 1'b1);
    chk("reset_all_zero", 32'({select1, select2, userquit, start_pulse, key_held, SW, sw_multi}), 32'd0);
    while (cyc < 10) applyStimulus(4'hF, 10'h0, 1'b0);

    // Clean press and release of KEY[0]
    clearCounts();
    dropC = cyc;
    repeat (12) applyStimulus(4'hE, 10'h0, 1'b0);
    repeat (10) applyStimulus(4'hF, 10'h0, 1'b0);
    chk("clean_pulse_count", 32'(nSel1), 32'd1);
    chk("clean_latency", 32'(lastSel1 - dropC), 32'd6);

    // Bounce on KEY[1]
    clearCounts();
    applyStimulus(4'hD, 10'h0, 1'b0);
    applyStimulus(4'hF, 10'h0, 1'b0);
    applyStimulus(4'hD, 10'h0, 1'b0);
    applyStimulus(4'hF, 10'h0, 1'b0);
    finalC = cyc;
    repeat (10) applyStimulus(4'hD, 10'h0, 1'b0);
    repeat (10) applyStimulus(4'hF, 10'h0, 1'b0);
    chk("bounce_pulse_count", 32'(nSel2), 32'd1);
    chk("bounce_latency", 32'(lastSel2 - finalC), 32'd6);

    // Quit masks select1
    clearCounts();
    repeat (8) applyStimulus(4'hA, 10'h0, 1'b0);
    repeat (10) applyStimulus(4'hF, 10'h0, 1'b0);
    chk("quit_count", 32'(nQuit), 32'd1);
    chk("quit_sel1_masked", 32'(quitSel1), 32'd0);
    chk("quit_sel1_total", 32'(nSel1), 32'd0);
    chk("quit_key_held", 32'(quitHeld), 32'h5);

    // Switch latency and multi-switch behaviour
    swC = cyc;
    repeat (SW_LAT - 1) applyStimulus(4'hF, 10'h008, 1'b0);
    chk("sw_before_latency", 32'(SW), 32'h0);
    applyStimulus(4'hF, 10'h008, 1'b0);
    chk("sw_at_latency", 32'(SW), 32'h008);
    chk("sw_latency_cycles", 32'(cyc - swC), 32'(SW_LAT));
    repeat (10) applyStimulus(4'hF, 10'h028, 1'b0);
`ifdef SW_ONEHOT_EN
    chk("sw_two_up", 32'(SW), 32'h0);
    chk("sw_multi_two_up", 32'(sw_multi), 32'd1);
`else
    chk("sw_two_up", 32'(SW), 32'h028);
    chk("sw_multi_two_up", 32'(sw_multi), 32'd0);
`endif
    repeat (10) applyStimulus(4'hF, 10'h0, 1'b0);

    // Reset in the middle of a KEY[3] count, key still held afterwards
    clearCounts();
    repeat (3) applyStimulus(4'h7, 10'h0, 1'b0);
    repeat (2) applyStimulus(4'h7, 10'h0, 1'b1);
    rstC = cyc;
    repeat (12) applyStimulus(4'h7, 10'h0, 1'b0);
    chk("rstmid_count", 32'(nStart), 32'd1);
    chk("rstmid_latency", 32'(lastStart - rstC), 32'd6);
    repeat (10) applyStimulus(4'hF, 10'h0, 1'b0);

    // Random bouncing inputs with occasional resets
    k = 4'hF; s = 10'h0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) k[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) s[$urandom_range(0, 9)] ^= 1'b1;
      r = ($urandom_range(0, 199) == 0);
      applyStimulus(k, s, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
